// File: rtl/inst_bank_rom.sv
// ============================================================================
// Module      : inst_bank_rom
// Description : Multi-bank instruction store. Each bank is filled by a streaming
//               loader and read through a registered opcode fetch port.
//               Optional per-word even parity: define INST_BANK_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_bank_rom #(
    parameter int OPW   = 9,
    parameter int PCW   = 10,
    parameter int BANKS = 4,
    localparam int BKW  = $clog2(BANKS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [BKW-1:0] bank_sel,
    input  logic           load_start,
    input  logic           ld_valid,
    input  logic [OPW-1:0] ld_data,
    input  logic           ld_last,
    output logic           ld_ready,
    output logic           load_done,
    output logic           busy,
    input  logic           fetch_en,
    input  logic [PCW-1:0] pgmCtr,
    output logic [OPW-1:0] opCde,
    output logic           op_valid,
    output logic           par_err
);

    localparam int DEPTH_ALL = BANKS * (2 ** PCW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BKW-1:0]   ld_bank_q, ld_bank_d;
    logic [PCW-1:0]   addr_q, addr_d;
    logic [BANKS-1:0] loaded_q, loaded_d;
    logic             load_done_q, load_done_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             op_valid_q, op_valid_d;
    logic             par_err_q, par_err_d;

    logic [OPW-1:0]   mem_q [DEPTH_ALL];

    logic                 w_start;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_fetch;
    logic                 w_par_bad;
    logic [BKW+PCW-1:0]   w_wr_idx;
    logic [BKW+PCW-1:0]   w_rd_idx;
    logic [OPW-1:0]       w_rd_word;

    assign w_start   = load_start && (state_q != S_LOAD);
    assign w_accept  = ld_valid && (state_q == S_LOAD);
    assign w_last    = w_accept && (ld_last || (addr_q == {PCW{1'b1}}));
    // load_start wins over a coincident fetch
    assign w_fetch   = fetch_en && (state_q != S_LOAD) && !load_start;
    assign w_wr_idx  = {ld_bank_q, addr_q};
    assign w_rd_idx  = {bank_sel, pgmCtr};
    assign w_rd_word = mem_q[w_rd_idx];

    // Storage is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[w_wr_idx] <= ld_data;
        end
    end

`ifdef INST_BANK_PARITY_EN
    logic par_mem_q [DEPTH_ALL];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            par_mem_q[w_wr_idx] <= ^ld_data;
        end
    end

    assign w_par_bad = (^w_rd_word) != par_mem_q[w_rd_idx];
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ld_bank_q   <= '0;
            addr_q      <= '0;
            loaded_q    <= '0;
            load_done_q <= 1'b0;
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_bank_q   <= ld_bank_d;
            addr_q      <= addr_d;
            loaded_q    <= loaded_d;
            load_done_q <= load_done_d;
            op_q        <= op_d;
            op_valid_q  <= op_valid_d;
            par_err_q   <= par_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_bank_d   = ld_bank_q;
        addr_d      = addr_q;
        loaded_d    = loaded_q;
        load_done_d = 1'b0;
        op_d        = op_q;
        op_valid_d  = 1'b0;
        par_err_d   = 1'b0;

        case (state_q)
            S_IDLE, S_READY: begin
                if (w_start) begin
                    state_d            = S_LOAD;
                    ld_bank_d          = bank_sel;
                    addr_d             = '0;
                    loaded_d[bank_sel] = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    loaded_d[ld_bank_q] = 1'b1;
                    load_done_d         = 1'b1;
                    state_d             = S_READY;
                end else if (w_accept) begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_fetch) begin
            op_valid_d = loaded_q[bank_sel];
            op_d       = loaded_q[bank_sel] ? w_rd_word : '0;
            par_err_d  = loaded_q[bank_sel] && w_par_bad;
        end
    end

    assign ld_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD);
    assign load_done = load_done_q;
    assign opCde     = op_q;
    assign op_valid  = op_valid_q;
    assign par_err   = par_err_q;

endmodule

`default_nettype wire

// File: doc/inst_bank_rom.md
INST_BANK_ROM -- requirements
Module: inst_bank_rom

Interface
REQ-001 SHALL have parameter OPW, default 9, opcode width in bits.
REQ-002 SHALL have parameter PCW, default 10, program-counter width; each bank depth 2**PCW words.
REQ-003 SHALL have parameter BANKS, default 4, number of program banks (power of two, >=2); BKW = log2(BANKS).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port bank_sel  input  BKW  bank for load start and fetch.
REQ-007 SHALL have port load_start  input  1  pulse: begin loading bank_sel.
REQ-008 SHALL have port ld_valid  input  1  loader word valid.
REQ-009 SHALL have port ld_data  input  OPW  loader word.
REQ-010 SHALL have port ld_last  input  1  marks final loader word.
REQ-011 SHALL have port ld_ready  output  1  block accepts loader word.
REQ-012 SHALL have port load_done  output  1  one-cycle pulse when a load completes.
REQ-013 SHALL have port busy  output  1  high while in LOAD.
REQ-014 SHALL have port fetch_en  input  1  fetch request.
REQ-015 SHALL have port pgmCtr  input  PCW  fetch address.
REQ-016 SHALL have port opCde  output  OPW  fetched opcode, registered.
REQ-017 SHALL have port op_valid  output  1  opCde valid this cycle.
REQ-018 SHALL have port par_err  output  1  parity mismatch on the word presented with op_valid.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, READY; state READY after reset is never entered without a completed load.
REQ-020 SHALL, on load_start in IDLE or READY, latch bank_sel into ld_bank, clear load address to 0, clear loaded[ld_bank], enter LOAD next cycle.
REQ-021 SHALL ignore load_start while in LOAD.
REQ-022 SHALL drive ld_ready = busy = 1 exactly when state is LOAD.
REQ-023 SHALL, on ld_valid && ld_ready, write ld_data to mem[ld_bank][addr] and increment addr (PCW bits).
REQ-024 SHALL end the load on an accepted word with ld_last=1, or on the accepted word at addr = 2**PCW-1 (no wrap): set loaded[ld_bank], pulse load_done next cycle, enter READY.
REQ-025 SHALL keep words beyond the last loaded address at their prior contents.
REQ-026 SHALL, for fetch_en in IDLE or READY, register mem[bank_sel][pgmCtr] into opCde with 1-cycle latency and op_valid=1 if loaded[bank_sel], else opCde=0 (NOP) and op_valid=0.
REQ-027 SHALL ignore fetch_en during LOAD: op_valid=0, opCde holds.
REQ-028 SHALL give load_start priority over a simultaneous fetch_en: fetch ignored, op_valid=0 next cycle.
REQ-029 SHALL hold opCde and drive op_valid=0 in any cycle following no accepted fetch.
REQ-030 SHALL allow fetching other loaded banks only outside LOAD; a bank under load reads as unloaded after the load completes only if reset intervenes.

Reset
REQ-031 SHALL on reset: state IDLE, addr=0, ld_bank=0, loaded all 0, opCde=0, op_valid=0, load_done=0, par_err=0; memory array not cleared.
REQ-032 SHALL on reset mid-load abandon the load; that bank remains unloaded.

Configuration
REQ-033 SHALL with INST_BANK_PARITY_EN defined store an even-parity bit per word on write and, on each valid fetch, drive par_err=1 alongside op_valid when recomputed parity mismatches.
REQ-034 SHALL without INST_BANK_PARITY_EN store no parity bit and tie par_err to 0.

Verification
REQ-035 SHALL verify: reset, fetch_en bank 0 pgmCtr 5 -> op_valid=0, opCde=0.
REQ-036 SHALL verify: load bank 2 with 0x101,0x0A5,0x1FF (ld_last on third) -> load_done pulse 1 cycle after third accept; fetch bank 2 addr 1 -> opCde=0x0A5, op_valid=1 next cycle.
REQ-037 SHALL verify: load bank 1 with 1024 words (no ld_last) -> completion after word 1023, addr not wrapped, fetch addr 1023 returns last word.
REQ-038 SHALL verify: fetch_en and load_start same cycle in READY -> op_valid=0, busy=1 next cycle; fetch during LOAD -> op_valid=0.
REQ-039 SHALL verify: reset after 2 of 5 load words to bank 3 -> fetch bank 3 op_valid=0; bank 2 contents still readable after reload of bank 2 only.
REQ-040 SHALL verify with INST_BANK_PARITY_EN: force stored parity bit flip at bank 2 addr 0 -> fetch gives par_err=1 with op_valid=1; without macro par_err=0.
